// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_lsu #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o,
  output logic        mem_enable_o,
  output logic        mem_read_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_in_o,
  input  logic [31:0] mem_data_out_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]           state_q,    state_d;
  logic [ADDR_BITS-1:0] waddr_q,    waddr_d;
  logic [1:0]           lane_q,     lane_d;
  logic [1:0]           size_q,     size_d;
  logic                 write_q,    write_d;
  logic                 unsigned_q, unsigned_d;
  logic [31:0]          wdata_q,    wdata_d;
  logic [31:0]          wr_data_q,  wr_data_d;
  logic [31:0]          rdata_q,    rdata_d;
  logic                 error_q,    error_d;

  logic        accept;
  logic        illegal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;
  logic [4:0]  mrg_shift;
  logic [31:0] mrg_mask;
  logic [31:0] merged;

  // Upper address bits wrap away; they are intentionally not stored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_BITS+2];

  assign accept  = req_valid_i && (state_q == S_IDLE);
  assign illegal = (req_size_i == 2'b11) ||
                   ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                   ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));

  // Lane extraction and store merge both operate on the word arriving from memory.
  always_comb begin
    ld_byte   = 8'(mem_data_out_i >> {lane_q, 3'b000});
    ld_half   = 16'(mem_data_out_i >> {lane_q[1], 4'b0000});
    ld_result = mem_data_out_i;
    case (size_q)
      SZ_BYTE: ld_result = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_result = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_result = mem_data_out_i;
    endcase
  end

  always_comb begin
    if (size_q == SZ_BYTE) begin
      mrg_shift = {lane_q, 3'b000};
      mrg_mask  = 32'h0000_00FF;
    end else begin
      mrg_shift = {lane_q[1], 4'b0000};
      mrg_mask  = 32'h0000_FFFF;
    end
    merged = (mem_data_out_i & ~(mrg_mask << mrg_shift)) |
             ((wdata_q & mrg_mask) << mrg_shift);
  end

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    lane_d     = lane_q;
    size_d     = size_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    wr_data_d  = wr_data_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          waddr_d    = req_addr_i[ADDR_BITS+1:2];
          lane_d     = req_addr_i[1:0];
          size_d     = req_size_i;
          write_d    = req_write_i;
          unsigned_d = req_unsigned_i;
          wdata_d    = req_wdata_i;
          wr_data_d  = req_wdata_i;
          rdata_d    = 32'h0;
          error_d    = illegal;
          if (illegal)
            state_d = S_RESP;
          else if (req_write_i && (req_size_i == SZ_WORD))
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (write_q) begin
          wr_data_d = merged;
          state_d   = S_WRITE;
        end else begin
          rdata_d = ld_result;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      wr_data_q  <= 32'h0;
      rdata_q    <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      wr_data_q  <= wr_data_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  // Memory strobes decode straight from state so an async reset drops them at once.
  assign req_ready_o   = (state_q == S_IDLE);
  assign resp_valid_o  = (state_q == S_RESP);
  assign resp_rdata_o  = rdata_q;
  assign resp_error_o  = error_q;
  assign mem_enable_o  = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_read_o    = (state_q == S_READ);
  assign mem_addr_o    = {{(32-ADDR_BITS){1'b0}}, waddr_q};
  assign mem_data_in_o = wr_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: word memory model on the memory side, byte-array reference model
// for expected load data, store words, latency and memory-cycle counts.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_enable, mem_read;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  int total = 0;
  int bad   = 0;

  bit [31:0] fmem [0:65535];
  bit [7:0]  rb   [0:262143];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  mem_lsu #(.ADDR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_error_o(resp_error), .mem_enable_o(mem_enable), .mem_read_o(mem_read),
    .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in), .mem_data_out_i(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) fmem[pre_addr] <= pre_data;
    if (mem_enable && mem_read) mem_data_out <= fmem[mem_addr[15:0]];
    if (mem_enable && !mem_read) fmem[mem_addr[15:0]] <= mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    return {rb[wa*4+3], rb[wa*4+2], rb[wa*4+1], rb[wa*4]};
  endfunction

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int ba, nb, explat, er, ew, cyc, nr, nw;
    logic err;
    logic [31:0] exp_rd, exp_ww, sign;
    ba  = int'(addr & 32'h0003_FFFF);
    nb  = 1 << sz;
    err = (sz == 2'd3) || (ba % nb != 0);
    exp_rd = 32'h0;
    exp_ww = 32'h0;
    if (err) begin explat = 1; er = 0; ew = 0; end
    else if (!wr) begin
      explat = 3; er = 1; ew = 0;
      for (int i = 0; i < nb; i++) exp_rd |= 32'(rb[ba+i]) << (8*i);
      if (nb < 4 && !uns && exp_rd[8*nb-1]) begin
        sign   = 32'hFFFF_FFFF << (8*nb);
        exp_rd = exp_rd | sign;
      end
    end else begin
      explat = (nb == 4) ? 2 : 4; er = (nb == 4) ? 0 : 1; ew = 1;
      for (int i = 0; i < nb; i++) rb[ba+i] = 8'(wd >> (8*i));
      exp_ww = ref_word(ba / 4);
    end
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    @(negedge clk);
    cyc = 1; nr = 0; nw = 0;
    while (!resp_valid && cyc < 8) begin
      chk("ready_busy", {31'h0, req_ready}, 32'h0);
      if (mem_enable) begin
        chk("mem_addr", mem_addr, 32'(ba / 4));
        if (mem_read) nr++;
        else begin
          nw++;
          chk("mem_wdata", mem_data_in, exp_ww);
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(explat));
    chk("rdata", resp_rdata, exp_rd);
    chk("error", {31'h0, resp_error}, {31'h0, err});
    chk("reads", 32'(nr), 32'(er));
    chk("writes", 32'(nw), 32'(ew));
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 32'h8899AABB;
    rb[16'h40] = 8'hBB; rb[16'h41] = 8'hAA; rb[16'h42] = 8'h99; rb[16'h43] = 8'h88;
    @(posedge clk);
    #1 pre_we = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_error", {31'h0, resp_error}, 32'h0);
    chk("rst_enable", {31'h0, mem_enable}, 32'h0);
    chk("rst_read", {31'h0, mem_read}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data_in", mem_data_in, 32'h0);
    rst_n = 1'b1;

    do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);          // -> FFFFFFAA
    do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);          // -> FFFF8899
    do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);          // -> 00008899
    do_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0);          // -> 000000BB
    do_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h12345677);   // write 7799AABB
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("plan_word_after_byte", ref_word(16), 32'h7799AABB);
    do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h45, 32'hFFFF);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFC_0040, 32'h0);   // wraps to word 0x10

    // Reset during CAPTURE of a half store must not write anything.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h5555; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_enable", {31'h0, mem_enable}, 32'h0);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
      chk("abort_no_mem", {31'h0, mem_enable}, 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_idle_resp", {31'h0, resp_valid}, 32'h0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);          // still 7799AABB

    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) sz = 2'b11;
      else if (sz == 2'b11) sz = 2'b10;
      a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(8, 24)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit that sits directly upstream of the word-wide fake memory and drives its clk/enable/read/addr/data_in/data_out interface.
- Accepts byte, halfword and word load/store requests from the CPU datapath.
- Converts byte addresses to word addresses.
- Performs read-modify-write for sub-word stores, because the memory has no byte enables.
- Extracts and sign- or zero-extends load data, and returns one response per request.

Parameters:
- ADDR_BITS, 16, memory word-address width (memory depth = 2^ADDR_BITS words).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend load result (ignored for word loads and for stores).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; valid bits are in the low lanes.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned access or illegal size; qualified by resp_valid.
- mem_enable  out  1  memory enable.
- mem_read  out  1  1 = read, 0 = write (meaningful only while mem_enable = 1).
- mem_addr  out  32  word address = {zeros, latched addr[ADDR_BITS+1:2]}.
- mem_data_in  out  32  write data to memory.
- mem_data_out  in  32  read data from memory; valid in the cycle after a read cycle.

Behaviour:
- Handshake:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - req_addr, req_wdata, req_size, req_write and req_unsigned are latched at acceptance.
  - Inputs are ignored while busy.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE:
  - On acceptance, go to RESP if the request is illegal.
  - Illegal means: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
  - A legal word store goes to WRITE; every other legal request goes to READ.
- READ: mem_enable = 1, mem_read = 1 for exactly one cycle; next state CAPTURE.
- CAPTURE:
  - Latch mem_data_out.
  - Load: compute the result and go to RESP.
  - Sub-word store: merge the new data into the captured word and go to WRITE.
- WRITE: mem_enable = 1, mem_read = 0, mem_data_in = merged word (or req_wdata for a word store) for exactly one cycle; next state RESP.
- RESP: resp_valid = 1 for one cycle; next state IDLE. A new request can be accepted in the following cycle.
- Outside READ and WRITE: mem_enable = 0, mem_read = 0.
- mem_addr always reflects the latched word address.
- Byte lanes are little-endian:
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Stores:
  - A byte store writes req_wdata[7:0] into its lane.
  - A half store writes req_wdata[15:0] into its lane.
  - All other lanes keep the captured values.
- Loads: sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned = 1, in which case zero-extend.
- Latency, counted from the acceptance edge; resp_valid is high in cycle:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Address handling:
  - Addresses above 2^(ADDR_BITS+2)-1 wrap: upper bits are dropped.
  - mem_addr bits above ADDR_BITS-1 are always 0.
- Errors cause no memory access; resp_rdata = 0 and resp_error = 1.
- Reset values: state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0, mem_enable = 0, mem_read = 0, mem_addr = 0, mem_data_in = 0, all latches 0.
- Reset mid-operation:
  - Return to IDLE immediately and drop mem_enable asynchronously.
  - No partial write may complete; no response is issued for the aborted request.

Test Plan:
- Preload word 0x10 = 0x8899AABB. Signed byte load at addr 0x41 -> mem_addr = 0x10, one read cycle, resp_valid in cycle 3, resp_rdata = 0xFFFFFFAA, resp_error = 0.
- Half loads at addr 0x42: signed -> 0xFFFF8899; unsigned -> 0x00008899; unsigned byte at 0x40 -> 0x000000BB.
- Byte store at 0x43 with data 0x12345677 -> READ then WRITE with mem_data_in = 0x7799AABB on word 0x10, resp_valid in cycle 4, resp_rdata = 0. Then word load at 0x40 -> 0x7799AABB.
- Word store at 0x44 with data 0xDEADBEEF -> no read cycle, single write to word 0x11, resp_valid in cycle 2. Back-to-back word load at 0x44, issued in the cycle after RESP -> 0xDEADBEEF.
- Misaligned requests: word load at 0x42, half store at 0x45, and size 11 -> each gives resp_error = 1, resp_rdata = 0, resp_valid in cycle 1, and mem_enable never asserted.
- Assert rst_n low during CAPTURE of a half store to 0x40 -> mem_enable stays 0, req_ready = 1 immediately, no resp_valid, and word 0x10 is unchanged on reread.
